// File: rtl/rs232_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures each character,
// releases the UART with a one-cycle readRX pulse, and queues it in a FWFT FIFO.
module rs232_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  charReady,
   input  logic [7:0]            RXchar,
   output logic                  readRX,
   input  logic                  pop,
   output logic [7:0]            dout,
   output logic                  notEmpty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  clrOverrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

   state_t                state, state_nx;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic                  capture, full, do_pop, do_push, drop;

   assign full     = (count == FULL_CNT);
   assign notEmpty = (count != '0);
   assign dout     = mem[rptr];

   // A pop frees a slot on the same edge, so a full FIFO still accepts the push.
   assign do_pop  = pop && notEmpty;
   assign do_push = capture && (!full || do_pop);
   assign drop    = capture && full && !do_pop;

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      case (state)
         IDLE: if (charReady) begin
            state_nx = ACK;
            capture  = 1'b1;
         end
         ACK:     state_nx = WAIT;
         WAIT:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         readRX <= 1'b0;
      end else begin
         state  <= state_nx;
         readRX <= (state_nx == ACK);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (drop)            overrun <= 1'b1;
         else if (clrOverrun) overrun <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= RXchar;
   end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: a simple UART model holds charReady until
// it sees readRX, and a byte queue tracks what should come out of the FIFO.
module tb_rs232_rx_fifo;

   logic       clock = 1'b0;
   logic       reset;
   logic       charReady, pop, clrOverrun;
   logic [7:0] RXchar;
   logic       readRX, notEmpty, overrun;
   logic [7:0] dout;
   logic [4:0] count;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q [$];

   rs232_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clock(clock), .reset(reset), .charReady(charReady), .RXchar(RXchar),
      .readRX(readRX), .pop(pop), .dout(dout), .notEmpty(notEmpty),
      .count(count), .overrun(overrun), .clrOverrun(clrOverrun)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // UART model: present a byte, wait for the release pulse, drop charReady.
   task automatic send_byte(input logic [7:0] b, input logic clr, output int lat);
      charReady = 1'b1; RXchar = b; clrOverrun = clr; lat = 0;
      while (!readRX && lat < 10) begin
         tick();
         lat++;
      end
      clrOverrun = 1'b0;
      checks++;
      if (readRX !== 1'b1) begin
         failures++;
         $display("FAIL readRX_timeout byte=%h got=%b want=1", b, readRX);
      end
      charReady = 1'b0;
      tick();
      checks++;
      if (readRX !== 1'b0) begin
         failures++;
         $display("FAIL readRX_width byte=%h got=%b want=0", b, readRX);
      end
      tick();
   endtask

   task automatic pop_check(input logic [7:0] exp, input string tag);
      checks++;
      if (notEmpty !== 1'b1 || dout !== exp) begin
         failures++;
         $display("FAIL %s notEmpty=%b dout=%h want notEmpty=1 dout=%h", tag, notEmpty, dout, exp);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; charReady = 1'b0; pop = 1'b0; clrOverrun = 1'b0; RXchar = 8'h00;
      #12;
      checks++;
      if (readRX !== 1'b0 || count !== 5'd0 || notEmpty !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_state readRX=%b count=%0d notEmpty=%b overrun=%b want 0/0/0/0",
                  readRX, count, notEmpty, overrun);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_capture();
      int lat;
      send_byte(8'h41, 1'b0, lat);
      checks++;
      if (lat < 1 || lat > 2) begin
         failures++;
         $display("FAIL capture_latency got=%0d want=1..2", lat);
      end
      checks++;
      if (notEmpty !== 1'b1 || dout !== 8'h41 || count !== 5'd1) begin
         failures++;
         $display("FAIL single_capture notEmpty=%b dout=%h count=%0d want 1/41/1", notEmpty, dout, count);
      end
      pop_check(8'h41, "single_pop");
   endtask

   task automatic test_full_overrun();
      int lat;
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, lat);
      checks++;
      if (count !== 5'd16 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL fill16 count=%0d overrun=%b want 16/0", count, overrun);
      end
      send_byte(8'hAA, 1'b0, lat);
      checks++;
      if (count !== 5'd16 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_drop count=%0d overrun=%b want 16/1", count, overrun);
      end
      for (int i = 0; i < 16; i++) pop_check(8'(i), "drain_order");
      checks++;
      if (count !== 5'd0 || notEmpty !== 1'b0) begin
         failures++;
         $display("FAIL drained count=%0d notEmpty=%b want 0/0", count, notEmpty);
      end
   endtask

   task automatic test_push_pop_same();
      int lat;
      send_byte(8'h55, 1'b0, lat);
      charReady = 1'b1; RXchar = 8'h66; pop = 1'b1;
      tick();
      pop = 1'b0; charReady = 1'b0;
      checks++;
      if (readRX !== 1'b1 || count !== 5'd1 || dout !== 8'h66) begin
         failures++;
         $display("FAIL push_pop_same readRX=%b count=%0d dout=%h want 1/1/66", readRX, count, dout);
      end
      tick(); tick();
      pop_check(8'h66, "after_push_pop");
      pop = 1'b1;
      tick();
      pop = 1'b0;
      checks++;
      if (count !== 5'd0 || notEmpty !== 1'b0) begin
         failures++;
         $display("FAIL pop_empty count=%0d notEmpty=%b want 0/0", count, notEmpty);
      end
   endtask

   task automatic test_wrap();
      int lat;
      for (int i = 0; i < 40; i++) begin
         send_byte(8'(8'h30 + i), 1'b0, lat);
         exp_q.push_back(8'(8'h30 + i));
         if (i % 3 != 0) pop_check(exp_q.pop_front(), "wrap_order");
      end
      checks++;
      if (count !== 5'(exp_q.size())) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=%0d", count, exp_q.size());
      end
      while (exp_q.size() > 0) pop_check(exp_q.pop_front(), "wrap_drain");
   endtask

   task automatic test_overrun_clear();
      int lat;
      clrOverrun = 1'b1;
      tick();
      clrOverrun = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0, lat);
      send_byte(8'hBB, 1'b1, lat);
      checks++;
      if (overrun !== 1'b1 || count !== 5'd16) begin
         failures++;
         $display("FAIL set_wins overrun=%b count=%0d want 1/16", overrun, count);
      end
      clrOverrun = 1'b1;
      tick();
      clrOverrun = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear got=%b want=0", overrun);
      end
      for (int i = 0; i < 16; i++) pop_check(8'(8'h80 + i), "ovr_drain");
   endtask

   task automatic test_reset_in_ack();
      int pulses = 0;
      charReady = 1'b1; RXchar = 8'h77;
      tick();
      checks++;
      if (readRX !== 1'b1) begin
         failures++;
         $display("FAIL ack_entry readRX=%b want=1", readRX);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (readRX !== 1'b0 || count !== 5'd0) begin
         failures++;
         $display("FAIL reset_in_ack readRX=%b count=%0d want 0/0", readRX, count);
      end
      #2 reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (readRX === 1'b1) begin
            pulses++;
            charReady = 1'b0;
         end
      end
      checks++;
      if (pulses != 1 || count !== 5'd1 || dout !== 8'h77) begin
         failures++;
         $display("FAIL recapture pulses=%0d count=%0d dout=%h want 1/1/77", pulses, count, dout);
      end
   endtask

   initial begin
      test_reset();
      test_single_capture();
      test_full_overrun();
      test_push_pop_same();
      test_wrap();
      test_overrun_clear();
      test_reset_in_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
